fb_sram_port: RTL and testbench

FB_SRAM_PORT -- requirements
Module: fb_sram_port

---
 rtl/fb_pkg.sv | 28 ++
 rtl/fb_req_slot.sv | 53 +++++
 rtl/fb_sram_port.sv | 238 +++++++++++++++++++++++
 tb/tb_fb_sram_port.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// -----------------------------------------------------------------------------
// fb_pkg -- shared definitions for the frame-buffer SRAM port.
//
// Contents:
//   FB_PIX_W     default pixel address width (one frame buffer half)
//   FB_WAIT_MAX  default number of SRAM wait cycles before an access is aborted
//   fb_state_e   access FSM states
//   rgb24_t      packed 24-bit pixel, r in the upper byte
// -----------------------------------------------------------------------------
package fb_pkg;

  localparam int FB_PIX_W    = 19;
  localparam int FB_WAIT_MAX = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_SWAP  = 2'd3
  } fb_state_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb24_t;

endpackage : fb_pkg

// File: rtl/fb_req_slot.sv
// -----------------------------------------------------------------------------
// fb_req_slot -- one-deep pending-request holder.
//
// A request pulse is captured together with its payload. The slot stays full
// until the consumer takes it. A request that arrives while the slot is full
// and not being taken in the same cycle is dropped and flagged on o_drop.
// A request coinciding with a take refills the slot, so back-to-back pulses
// are never lost just because the consumer was emptying the slot that cycle.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   i_req       request pulse
//   i_data      payload sampled with i_req
//   i_take      consumer removes the held request this cycle
//   o_valid     slot holds a request
//   o_data      held payload
//   o_drop      request lost because the slot was full (combinational)
// -----------------------------------------------------------------------------
module fb_req_slot #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_req,
  input  logic [W-1:0] i_data,
  input  logic         i_take,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic         o_drop
);

  logic         r_valid;
  logic [W-1:0] r_data;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_req && (!r_valid || i_take)) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_take) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_drop  = i_req && r_valid && !i_take;

endmodule : fb_req_slot

// File: rtl/fb_sram_port.sv
// -----------------------------------------------------------------------------
// fb_sram_port -- serialises alpha-blender pixel reads/writes and end-of-frame
// buffer swaps onto a single SRAM port with ack handshake and wait timeout.
//
// Optional feature: define FB_DOUBLE_BUFFER_EN to enable double buffering.
// buf_sel then toggles on every swap and selects the half the blender works
// on (the display scans the opposite half). Without it buf_sel is tied to 0
// and a swap only pulses swap_done.
//
// Ports:
//   clk, reset                  clock, asynchronous active-low reset
//   pixel_number [PIX_W-1:0]    pixel address for read/write requests
//   read, write                 request pulses from the blender
//   write_r/g/b                 pixel to store
//   read_r/g/b, read_valid      fetched pixel and its one-cycle strobe
//   o_frame_ready               end-of-frame pulse from the blender
//   swap_done                   one-cycle strobe when the swap completes
//   sram_addr [PIX_W:0]         {buf_sel, pixel}
//   sram_wdata, sram_rdata      24-bit {r,g,b}
//   sram_we, sram_oe, sram_ack  SRAM strobes and completion
//   busy                        FSM not idle
//   err                         sticky: dropped request or access timeout
//
// Service order is write > read > swap, so a read of a pixel always observes
// a write to it captured no later, and a swap waits until both slots drain.
// -----------------------------------------------------------------------------
module fb_sram_port
  import fb_pkg::*;
#(
  parameter int PIX_W    = FB_PIX_W,
  parameter int WAIT_MAX = FB_WAIT_MAX
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PIX_W-1:0] pixel_number,
  input  logic             read,
  input  logic             write,
  input  logic [7:0]       write_r,
  input  logic [7:0]       write_g,
  input  logic [7:0]       write_b,
  output logic [7:0]       read_r,
  output logic [7:0]       read_g,
  output logic [7:0]       read_b,
  output logic             read_valid,
  input  logic             o_frame_ready,
  output logic             swap_done,
  output logic [PIX_W:0]   sram_addr,
  output logic [23:0]      sram_wdata,
  input  logic [23:0]      sram_rdata,
  output logic             sram_we,
  output logic             sram_oe,
  input  logic             sram_ack,
  output logic             busy,
  output logic             err
);

  localparam int                CNT_W     = $clog2(WAIT_MAX + 1);
  localparam logic [CNT_W-1:0]  WAIT_LAST = CNT_W'(WAIT_MAX - 1);
  localparam int                WR_W      = PIX_W + 24;

  fb_state_e          r_state;
  fb_state_e          w_next;
  logic [CNT_W-1:0]   r_wait;
  logic [PIX_W:0]     r_addr;
  rgb24_t             r_wdata;
  rgb24_t             r_rd_pix;
  logic               r_read_valid;
  logic               r_err;
  logic               w_buf_sel;

  // ---------------------------------------------------------------------------
  // Pending-request slots
  // ---------------------------------------------------------------------------
  rgb24_t             w_wr_pix;
  logic               w_wr_valid, w_wr_take, w_wr_drop;
  logic [WR_W-1:0]    w_wr_data;
  logic               w_rd_valid, w_rd_take, w_rd_drop;
  logic [PIX_W-1:0]   w_rd_addr;
  logic               w_fr_valid, w_fr_take, w_fr_drop;
  logic [0:0]         w_fr_mark;

  assign w_wr_pix = {write_r, write_g, write_b};

  fb_req_slot #(.W(WR_W)) u_wr_slot (
    .clk     (clk),
    .rst_n   (reset),
    .i_req   (write),
    .i_data  ({pixel_number, w_wr_pix}),
    .i_take  (w_wr_take),
    .o_valid (w_wr_valid),
    .o_data  (w_wr_data),
    .o_drop  (w_wr_drop)
  );

  fb_req_slot #(.W(PIX_W)) u_rd_slot (
    .clk     (clk),
    .rst_n   (reset),
    .i_req   (read),
    .i_data  (pixel_number),
    .i_take  (w_rd_take),
    .o_valid (w_rd_valid),
    .o_data  (w_rd_addr),
    .o_drop  (w_rd_drop)
  );

  // The frame slot has no payload; it carries a constant marker bit.
  fb_req_slot #(.W(1)) u_fr_slot (
    .clk     (clk),
    .rst_n   (reset),
    .i_req   (o_frame_ready),
    .i_data  (1'b1),
    .i_take  (w_fr_take),
    .o_valid (w_fr_valid),
    .o_data  (w_fr_mark),
    .o_drop  (w_fr_drop)
  );

  // ---------------------------------------------------------------------------
  // Access FSM
  // ---------------------------------------------------------------------------
  logic w_active;
  logic w_expire;
  logic w_done;

  assign w_active = (r_state == ST_WRITE) || (r_state == ST_READ);
  assign w_expire = (r_wait == WAIT_LAST);
  assign w_done   = sram_ack || w_expire;

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    w_next    = r_state;
    w_wr_take = 1'b0;
    w_rd_take = 1'b0;
    w_fr_take = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_wr_valid) begin
          w_next    = ST_WRITE;
          w_wr_take = 1'b1;
        end else if (w_rd_valid) begin
          w_next    = ST_READ;
          w_rd_take = 1'b1;
        end else if (w_fr_valid && w_fr_mark[0]) begin
          w_next    = ST_SWAP;
          w_fr_take = 1'b1;
        end
      end
      ST_WRITE, ST_READ: begin
        if (w_done) w_next = ST_IDLE;
      end
      ST_SWAP: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // NOTE: the state register resets asynchronously, so sram_we/sram_oe,
  // decoded from it, fall the moment reset goes low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_wait  <= '0;
    end else begin
      r_state <= w_next;
      if (w_active && !w_done) r_wait <= r_wait + CNT_W'(1);
      else                     r_wait <= '0;
    end
  end

  // Address and data are frozen when an access is launched and held for the
  // whole WRITE/READ state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_wr_take) begin
      r_addr  <= {w_buf_sel, w_wr_data[WR_W-1:24]};
      r_wdata <= w_wr_data[23:0];
    end else if (w_rd_take) begin
      r_addr  <= {w_buf_sel, w_rd_addr};
    end
  end

  // Read return: a timed-out read still completes, with a zero pixel.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_pix     <= '0;
      r_read_valid <= 1'b0;
    end else if ((r_state == ST_READ) && sram_ack) begin
      r_rd_pix     <= sram_rdata;
      r_read_valid <= 1'b1;
    end else if ((r_state == ST_READ) && w_expire) begin
      r_rd_pix     <= '0;
      r_read_valid <= 1'b1;
    end else begin
      r_read_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err <= 1'b0;
    end else if (w_wr_drop || w_rd_drop || w_fr_drop ||
                 (w_active && w_expire && !sram_ack)) begin
      r_err <= 1'b1;
    end
  end

`ifdef FB_DOUBLE_BUFFER_EN
  logic r_buf_sel;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                   r_buf_sel <= 1'b0;
    else if (r_state == ST_SWAP)  r_buf_sel <= ~r_buf_sel;
  end

  assign w_buf_sel = r_buf_sel;
`else
  assign w_buf_sel = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Outputs. read_valid is only ever high in the first IDLE cycle after READ,
  // and swap_done only in SWAP, so the two strobes can never coincide.
  // ---------------------------------------------------------------------------
  assign sram_we    = (r_state == ST_WRITE);
  assign sram_oe    = (r_state == ST_READ);
  assign sram_addr  = r_addr;
  assign sram_wdata = r_wdata;
  assign read_r     = r_rd_pix.r;
  assign read_g     = r_rd_pix.g;
  assign read_b     = r_rd_pix.b;
  assign read_valid = r_read_valid;
  assign swap_done  = (r_state == ST_SWAP);
  assign busy       = (r_state != ST_IDLE);
  assign err        = r_err;

endmodule : fb_sram_port

// File: tb/tb_fb_sram_port.sv
// -----------------------------------------------------------------------------
// tb_fb_sram_port -- directed bench for fb_sram_port with a behavioural SRAM
// that acks after a programmable number of cycles of an active strobe.
// -----------------------------------------------------------------------------
module tb_fb_sram_port;

  localparam int PIX_W = 19;

`ifdef FB_DOUBLE_BUFFER_EN
  localparam logic [PIX_W:0] BANK_AFTER_SWAP = 20'h80000;
`else
  localparam logic [PIX_W:0] BANK_AFTER_SWAP = 20'h00000;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic [PIX_W-1:0] pixel_number;
  logic             read, write;
  logic [7:0]       write_r, write_g, write_b;
  logic [7:0]       read_r, read_g, read_b;
  logic             read_valid;
  logic             o_frame_ready;
  logic             swap_done;
  logic [PIX_W:0]   sram_addr;
  logic [23:0]      sram_wdata;
  logic [23:0]      sram_rdata = 24'h0;
  logic             sram_we, sram_oe;
  logic             sram_ack = 1'b0;
  logic             busy, err;

  int total = 0;
  int bad   = 0;

  fb_sram_port dut (
    .clk           (clk),
    .reset         (reset),
    .pixel_number  (pixel_number),
    .read          (read),
    .write         (write),
    .write_r       (write_r),
    .write_g       (write_g),
    .write_b       (write_b),
    .read_r        (read_r),
    .read_g        (read_g),
    .read_b        (read_b),
    .read_valid    (read_valid),
    .o_frame_ready (o_frame_ready),
    .swap_done     (swap_done),
    .sram_addr     (sram_addr),
    .sram_wdata    (sram_wdata),
    .sram_rdata    (sram_rdata),
    .sram_we       (sram_we),
    .sram_oe       (sram_oe),
    .sram_ack      (sram_ack),
    .busy          (busy),
    .err           (err)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // SRAM model: acks in the ack_delay-th cycle of an access, commits writes
  // on ack, returns stored data (0 if never written) while oe is high.
  // ---------------------------------------------------------------------------
  logic [23:0] mem [int];
  int          ack_delay = 1;
  bit          hold_ack  = 1'b0;
  int          op_cnt    = 0;

  always @(negedge clk) begin
    if (sram_we || sram_oe) begin
      op_cnt   = op_cnt + 1;
      sram_ack = !hold_ack && (op_cnt == ack_delay);
      if (sram_oe)
        sram_rdata = mem.exists(int'(sram_addr)) ? mem[int'(sram_addr)] : 24'h0;
      if (sram_we && sram_ack)
        mem[int'(sram_addr)] = sram_wdata;
    end else begin
      op_cnt   = 0;
      sram_ack = 1'b0;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    read          = 1'b0;
    write         = 1'b0;
    o_frame_ready = 1'b0;
    pixel_number  = '0;
    write_r       = 8'h0;
    write_g       = 8'h0;
    write_b       = 8'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    repeat (3) tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err); end
    total++; if ({sram_we, sram_oe} !== 2'b00) begin bad++; $display("FAIL reset_we_oe: got %b want 00", {sram_we, sram_oe}); end
    total++; if (sram_addr !== 20'h0) begin bad++; $display("FAIL reset_addr: got %h want 0", sram_addr); end
    total++; if (sram_wdata !== 24'h0) begin bad++; $display("FAIL reset_wdata: got %h want 0", sram_wdata); end
    total++; if ({read_r, read_g, read_b} !== 24'h0) begin bad++; $display("FAIL reset_rdata: got %h want 0", {read_r, read_g, read_b}); end
    total++; if ({read_valid, swap_done} !== 2'b00) begin bad++; $display("FAIL reset_strobes: got %b want 00", {read_valid, swap_done}); end
    reset = 1'b1;
    repeat (3) tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle_after_release: busy got %b want 0", busy); end
  endtask

  // Write pixel 5 = 80/40/C0, SRAM acks in the 2nd cycle.
  task automatic test_write();
    int          we_cnt = 0;
    logic [19:0] a = '0;
    logic [23:0] d = '0;
    bit          unstable = 1'b0;
    ack_delay    = 2;
    pixel_number = 19'd5;
    {write_r, write_g, write_b} = 24'h8040C0;
    write = 1'b1;
    tick();
    idle_inputs();
    for (int k = 1; k <= 8; k++) begin
      if (sram_we) begin
        if (we_cnt > 0 && (sram_addr !== a || sram_wdata !== d)) unstable = 1'b1;
        a = sram_addr;
        d = sram_wdata;
        we_cnt++;
      end
      tick();
    end
    total++; if (we_cnt != 2) begin bad++; $display("FAIL write_we_cycles: got %0d want 2", we_cnt); end
    total++; if (a !== 20'd5) begin bad++; $display("FAIL write_addr: got %h want 00005", a); end
    total++; if (d !== 24'h8040C0) begin bad++; $display("FAIL write_wdata: got %h want 8040c0", d); end
    total++; if (unstable !== 1'b0) begin bad++; $display("FAIL write_stable: got unstable=%b want 0", unstable); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL write_err: got %b want 0", err); end
  endtask

  // Read pixel 5 holding 010203 with a zero-wait ack: strobe 3 cycles later.
  task automatic test_read_latency();
    int          first = 0;
    int          rv_cnt = 0;
    logic [23:0] got = '0;
    mem[5]       = 24'h010203;
    ack_delay    = 1;
    pixel_number = 19'd5;
    read = 1'b1;
    tick();
    idle_inputs();
    for (int k = 1; k <= 8; k++) begin
      if (read_valid) begin
        rv_cnt++;
        if (first == 0) begin
          first = k;
          got   = {read_r, read_g, read_b};
        end
      end
      tick();
    end
    total++; if (first != 3) begin bad++; $display("FAIL read_latency: got %0d want 3", first); end
    total++; if (rv_cnt != 1) begin bad++; $display("FAIL read_valid_pulses: got %0d want 1", rv_cnt); end
    total++; if (got !== 24'h010203) begin bad++; $display("FAIL read_data: got %h want 010203", got); end
  endtask

  // Same-cycle read and write of pixel 7: write goes first, read sees it.
  task automatic test_back_to_back();
    int          we_k = 0;
    int          oe_k = 0;
    logic [23:0] got = '0;
    ack_delay    = 1;
    pixel_number = 19'd7;
    {write_r, write_g, write_b} = 24'h112233;
    read  = 1'b1;
    write = 1'b1;
    tick();
    idle_inputs();
    for (int k = 1; k <= 10; k++) begin
      if (sram_we && we_k == 0) we_k = k;
      if (sram_oe && oe_k == 0) oe_k = k;
      if (read_valid) got = {read_r, read_g, read_b};
      tick();
    end
    total++; if (we_k != 2) begin bad++; $display("FAIL rw_write_cycle: got %0d want 2", we_k); end
    total++; if (oe_k != 4) begin bad++; $display("FAIL rw_read_cycle: got %0d want 4", oe_k); end
    total++; if (got !== 24'h112233) begin bad++; $display("FAIL rw_read_data: got %h want 112233", got); end
  endtask

  // Frame end while a read is pending: read strobe, then swap strobe.
  task automatic test_swap();
    int          rv_k = 0;
    int          sd_k = 0;
    int          sd_cnt = 0;
    bit          both = 1'b0;
    logic [19:0] a = '0;
    ack_delay    = 1;
    pixel_number = 19'd9;
    read = 1'b1;
    tick();
    for (int k = 1; k <= 10; k++) begin
      if (k == 1) begin
        read          = 1'b0;
        o_frame_ready = 1'b1;
      end else if (k == 2) begin
        o_frame_ready = 1'b0;
      end
      if (read_valid && rv_k == 0) rv_k = k;
      if (swap_done) begin
        sd_cnt++;
        if (sd_k == 0) sd_k = k;
      end
      if (read_valid && swap_done) both = 1'b1;
      tick();
    end
    total++; if (rv_k != 3) begin bad++; $display("FAIL swap_read_first: read_valid at %0d want 3", rv_k); end
    total++; if (sd_k != 4) begin bad++; $display("FAIL swap_done_cycle: got %0d want 4", sd_k); end
    total++; if (sd_cnt != 1) begin bad++; $display("FAIL swap_done_pulses: got %0d want 1", sd_cnt); end
    total++; if (both !== 1'b0) begin bad++; $display("FAIL swap_overlap: got %b want 0", both); end

    pixel_number = 19'd3;
    {write_r, write_g, write_b} = 24'hABCDEF;
    write = 1'b1;
    tick();
    idle_inputs();
    for (int k = 1; k <= 6; k++) begin
      if (sram_we) a = sram_addr;
      tick();
    end
    total++; if (a !== (BANK_AFTER_SWAP | 20'd3)) begin bad++; $display("FAIL swap_next_write_addr: got %h want %h", a, BANK_AFTER_SWAP | 20'd3); end
  endtask

  // Third write while one is in flight and one is pending is dropped.
  task automatic test_drop();
    int base;
    base      = int'(BANK_AFTER_SWAP);
    ack_delay = 2;
    total++; if (err !== 1'b0) begin bad++; $display("FAIL drop_err_before: got %b want 0", err); end
    pixel_number = 19'd20; {write_r, write_g, write_b} = 24'hA0A0A0; write = 1'b1;
    tick();
    pixel_number = 19'd21; {write_r, write_g, write_b} = 24'hB1B1B1;
    tick();
    pixel_number = 19'd22; {write_r, write_g, write_b} = 24'hC2C2C2;
    tick();
    idle_inputs();
    repeat (10) tick();
    total++; if (err !== 1'b1) begin bad++; $display("FAIL drop_err_after: got %b want 1", err); end
    total++; if (!mem.exists(base + 20) || mem[base + 20] !== 24'hA0A0A0) begin bad++; $display("FAIL drop_first_kept: pixel 20 not written with a0a0a0"); end
    total++; if (!mem.exists(base + 21) || mem[base + 21] !== 24'hB1B1B1) begin bad++; $display("FAIL drop_second_kept: pixel 21 not written with b1b1b1"); end
    total++; if (mem.exists(base + 22)) begin bad++; $display("FAIL drop_third: pixel 22 got %h want not written", mem[base + 22]); end
  endtask

  // No ack on a read: abort after 15 cycles with zero data and err.
  task automatic test_timeout();
    int          oe_cnt = 0;
    int          rv_cnt = 0;
    logic [23:0] got = 24'h555555;
    do_reset();
    total++; if (err !== 1'b0) begin bad++; $display("FAIL timeout_err_before: got %b want 0", err); end
    mem[4]       = 24'hFFFFFF;
    hold_ack     = 1'b1;
    pixel_number = 19'd4;
    read = 1'b1;
    tick();
    idle_inputs();
    for (int k = 1; k <= 25; k++) begin
      if (sram_oe) oe_cnt++;
      if (read_valid) begin
        rv_cnt++;
        got = {read_r, read_g, read_b};
      end
      tick();
    end
    hold_ack = 1'b0;
    total++; if (oe_cnt != 15) begin bad++; $display("FAIL timeout_cycles: got %0d want 15", oe_cnt); end
    total++; if (rv_cnt != 1) begin bad++; $display("FAIL timeout_read_valid: got %0d want 1", rv_cnt); end
    total++; if (got !== 24'h0) begin bad++; $display("FAIL timeout_data: got %h want 000000", got); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL timeout_err: got %b want 1", err); end
  endtask

  // Reset pulled low in the middle of a WRITE with a read pending.
  task automatic test_reset_mid_write();
    bit woke = 1'b0;
    do_reset();
    hold_ack     = 1'b1;
    pixel_number = 19'd6;
    {write_r, write_g, write_b} = 24'h0F0F0F;
    write = 1'b1;
    tick();
    write        = 1'b0;
    pixel_number = 19'd8;
    read         = 1'b1;
    tick();
    idle_inputs();
    total++; if (sram_we !== 1'b1) begin bad++; $display("FAIL rstmid_in_write: sram_we got %b want 1", sram_we); end
    #2 reset = 1'b0;
    #1;
    total++; if (sram_we !== 1'b0) begin bad++; $display("FAIL rstmid_we_async: got %b want 0", sram_we); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy_async: got %b want 0", busy); end
    repeat (2) tick();
    reset    = 1'b1;
    hold_ack = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (busy || sram_we || sram_oe) woke = 1'b1;
      tick();
    end
    total++; if (woke !== 1'b0) begin bad++; $display("FAIL rstmid_pending_cleared: activity got %b want 0", woke); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rstmid_err: got %b want 0", err); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_latency();
    test_back_to_back();
    test_swap();
    test_drop();
    test_timeout();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_fb_sram_port
